// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing and text-cell address generator
module vga_timing_gen #(
  parameter int H_VISIBLE    = 800,
  parameter int H_FRONT      = 56,
  parameter int H_SYNC       = 120,
  parameter int H_BACK       = 64,
  parameter int V_VISIBLE    = 600,
  parameter int V_FRONT      = 37,
  parameter int V_SYNC       = 6,
  parameter int V_BACK       = 23,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 10,
  parameter int LOAD_LEAD    = 7,
  parameter int DESIGN_DELAY = 2,
  parameter int COORD_W      = 11,
  parameter int COL_W        = 7,
  parameter int ROW_W        = 6,
  parameter int BLINK_BIT    = 5,
  parameter int XCHAR_W      = (CHAR_W > 1) ? $clog2(CHAR_W) : 1,
  parameter int YCHAR_W      = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic [XCHAR_W-1:0] xchar,
  output logic [YCHAR_W-1:0] ychar,
  output logic [COL_W-1:0]   xtext,
  output logic [ROW_W-1:0]   ytext,
  output logic               drawing,
  output logic               loading,
  output logic               clk_load_char,
  output logic               clk_load_design,
  output logic               clk_draw_char,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count,
  output logic               blink
);

  localparam int H_TOTAL = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
  localparam int V_TOTAL = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;
  localparam int LOG2_CW = $clog2(CHAR_W);

  // Line layout: back porch, visible, front porch, sync.
  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_DRAW_BEG = COORD_W'(H_BACK);
  localparam logic [COORD_W-1:0] H_DRAW_END = COORD_W'(H_BACK + H_VISIBLE);
  localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_BACK + H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] H_LOAD_BEG = COORD_W'(H_BACK - LOAD_LEAD);
  localparam logic [COORD_W-1:0] H_LOAD_END = COORD_W'(H_BACK + H_VISIBLE - LOAD_LEAD);
  localparam logic [COORD_W-1:0] H_DSGN_BEG = COORD_W'(H_BACK - LOAD_LEAD + DESIGN_DELAY);
  localparam logic [COORD_W-1:0] H_DSGN_END = COORD_W'(H_BACK + H_VISIBLE - LOAD_LEAD + DESIGN_DELAY);

  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_DRAW_BEG = COORD_W'(V_BACK);
  localparam logic [COORD_W-1:0] V_DRAW_END = COORD_W'(V_BACK + V_VISIBLE);
  localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_BACK + V_VISIBLE + V_FRONT);

  // CHAR_W is a power of two, so "mod CHAR_W" is a mask and "/CHAR_W" a shift.
  localparam logic [COORD_W-1:0] CW_MASK    = COORD_W'(CHAR_W - 1);
  localparam logic [YCHAR_W-1:0] CH_LAST    = YCHAR_W'(CHAR_H - 1);

  logic [COORD_W-1:0] xpos_q, xpos_d;
  logic [COORD_W-1:0] ypos_q, ypos_d;
  logic [7:0]         frame_q, frame_d;
  logic [YCHAR_W-1:0] cell_line_q, cell_line_d;
  logic [ROW_W-1:0]   cell_row_q, cell_row_d;

  logic               hdraw;
  logic               vdraw;
  logic               hload;
  logic               hdsgn;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] lx;
  logic [COORD_W-1:0] ldx;

  // Window decode and cell offsets from the current raster position.
  always_comb begin
    hdraw = (xpos_q >= H_DRAW_BEG) && (xpos_q < H_DRAW_END);
    vdraw = (ypos_q >= V_DRAW_BEG) && (ypos_q < V_DRAW_END);
    hload = (xpos_q >= H_LOAD_BEG) && (xpos_q < H_LOAD_END);
    hdsgn = (xpos_q >= H_DSGN_BEG) && (xpos_q < H_DSGN_END);
    dx    = xpos_q - H_DRAW_BEG;
    lx    = xpos_q - H_LOAD_BEG;
    ldx   = xpos_q - H_DSGN_BEG;
  end

  // Raster, frame and text-row counters; everything holds while ce is low.
  always_comb begin
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    frame_d     = frame_q;
    cell_line_d = cell_line_q;
    cell_row_d  = cell_row_q;
    if (ce) begin
      if (xpos_q == H_LAST) begin
        xpos_d = '0;
        if (ypos_q == V_LAST) begin
          ypos_d  = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          ypos_d = ypos_q + COORD_W'(1);
        end
        // Rows are counted incrementally from the first visible line instead of dividing ypos.
        if (ypos_d == V_DRAW_BEG) begin
          cell_line_d = '0;
          cell_row_d  = '0;
        end else if (vdraw) begin
          if (cell_line_q == CH_LAST) begin
            cell_line_d = '0;
            cell_row_d  = cell_row_q + ROW_W'(1);
          end else begin
            cell_line_d = cell_line_q + YCHAR_W'(1);
          end
        end
      end else begin
        xpos_d = xpos_q + COORD_W'(1);
      end
    end
  end

  // State register with asynchronous restart at (0,0), frame 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xpos_q      <= '0;
      ypos_q      <= '0;
      frame_q     <= '0;
      cell_line_q <= '0;
      cell_row_q  <= '0;
    end else begin
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      frame_q     <= frame_d;
      cell_line_q <= cell_line_d;
      cell_row_q  <= cell_row_d;
    end
  end

  // Outputs are pure decode of the registers, forced to idle values while reset is held.
  always_comb begin
    xpos            = xpos_q;
    ypos            = ypos_q;
    hsync           = ~HSYNC_POL;
    vsync           = ~VSYNC_POL;
    drawing         = 1'b0;
    loading         = 1'b0;
    xchar           = '0;
    ychar           = '0;
    xtext           = '0;
    ytext           = '0;
    clk_load_char   = 1'b0;
    clk_load_design = 1'b0;
    clk_draw_char   = 1'b0;
    line_start      = 1'b0;
    frame_start     = 1'b0;
    frame_count     = '0;
    blink           = 1'b0;
    if (!reset) begin
      hsync           = (xpos_q >= H_SYNC_BEG) ? HSYNC_POL : ~HSYNC_POL;
      vsync           = (ypos_q >= V_SYNC_BEG) ? VSYNC_POL : ~VSYNC_POL;
      drawing         = hdraw && vdraw;
      loading         = hload && vdraw;
      if (hdraw && vdraw) begin
        xchar = XCHAR_W'(dx & CW_MASK);
        ychar = cell_line_q;
      end
      if (hload && vdraw) begin
        xtext = COL_W'(lx >> LOG2_CW);
      end
      if (vdraw) begin
        ytext = cell_row_q;
      end
      // Load strobes fire on every cell boundary of the load window regardless of vdraw.
      clk_load_char   = hload && ((lx & CW_MASK) == '0);
      clk_load_design = hdsgn && ((ldx & CW_MASK) == '0);
      clk_draw_char   = hdraw && vdraw && ((dx & CW_MASK) == '0);
      line_start      = (xpos_q == '0);
      frame_start     = (xpos_q == '0) && (ypos_q == '0);
      frame_count     = frame_q;
      blink           = frame_q[BLINK_BIT];
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

  // Small mode so several whole frames fit in the run.
  localparam int HV = 40, HF = 4, HS = 6, HB = 12;
  localparam int VV = 20, VF = 2, VS = 3, VB = 5;
  localparam int CW = 4, CH = 3, LL = 7, DD = 2, BB = 1;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int HT = HB + HV + HF + HS;
  localparam int VT = VB + VV + VF + VS;
  localparam int NCYC = 12000;

  typedef logic [56:0] vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        hsync, vsync;
  logic [10:0] xpos, ypos;
  logic [1:0]  xchar, ychar;
  logic [6:0]  xtext;
  logic [5:0]  ytext;
  logic        drawing, loading, clk_load_char, clk_load_design, clk_draw_char;
  logic        line_start, frame_start, blink;
  logic [7:0]  frame_count;
  vec_t        act;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  int   mx = 0, my = 0, mf = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .CHAR_W(CW), .CHAR_H(CH),
    .LOAD_LEAD(LL), .DESIGN_DELAY(DD), .COORD_W(11), .COL_W(7), .ROW_W(6),
    .BLINK_BIT(BB)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hsync), .vsync(vsync), .xpos(xpos), .ypos(ypos),
    .xchar(xchar), .ychar(ychar), .xtext(xtext), .ytext(ytext),
    .drawing(drawing), .loading(loading),
    .clk_load_char(clk_load_char), .clk_load_design(clk_load_design),
    .clk_draw_char(clk_draw_char), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count), .blink(blink)
  );

  always #5 clk = ~clk;

  assign act = {hsync, vsync, xpos, ypos, xchar, ychar, xtext, ytext,
                drawing, loading, clk_load_char, clk_load_design, clk_draw_char,
                line_start, frame_start, frame_count, blink};

  function automatic vec_t model_vec(int x, int y, int f, bit r);
    bit hd, vd, dr, ld, clc, cld, cdc;
    int xc, yc, xt, yt;
    logic [7:0] f8;
    if (r) return {~HP, ~VP, 55'd0};
    hd  = (x >= HB) && (x < HB + HV);
    vd  = (y >= VB) && (y < VB + VV);
    dr  = hd && vd;
    ld  = vd && (x >= HB - LL) && (x < HB + HV - LL);
    xc  = dr ? (x - HB) % CW : 0;
    yc  = dr ? (y - VB) % CH : 0;
    xt  = ld ? (x - HB + LL) / CW : 0;
    yt  = vd ? (y - VB) / CH : 0;
    clc = (x >= HB - LL) && (x < HB + HV - LL) && ((x - HB + LL) % CW == 0);
    cld = (x >= HB - LL + DD) && (x < HB + HV - LL + DD) && ((x - HB + LL - DD) % CW == 0);
    cdc = dr && (xc == 0);
    f8  = 8'(f);
    return {(x >= HB + HV + HF) ? HP : ~HP, (y >= VB + VV + VF) ? VP : ~VP,
            11'(x), 11'(y), 2'(xc), 2'(yc), 7'(xt), 6'(yt),
            dr, ld, clc, cld, cdc, (x == 0), (x == 0) && (y == 0), f8, f8[BB]};
  endfunction

  task automatic check_now(input string name, input vec_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, e);
    end
  endtask

  // Driver: picks ce (and occasional resets) and queues the state expected after the next edge.
  initial begin
    repeat (3) @(negedge clk);
    check_now("reset_state", model_vec(0, 0, 0, 1'b1));
    reset = 1'b0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      if (i == 700 || i == 11000) begin
        #2 reset = 1'b1;
        mx = 0; my = 0; mf = 0;
        #1 check_now("async_reset", model_vec(0, 0, 0, 1'b1));
        exp_q.push_back(model_vec(0, 0, 0, 1'b1));
        pushed++;
      end else begin
        reset = 1'b0;
        if (i < 200) ce = 1'b1;
        else if (i < 400) ce = (i % 2 == 0);
        else ce = ($urandom_range(0, 3) != 0);
        if (ce) begin
          mx++;
          if (mx == HT) begin
            mx = 0;
            my++;
            if (my == VT) begin
              my = 0;
              mf = (mf + 1) % 256;
            end
          end
        end
        exp_q.push_back(model_vec(mx, my, mf, 1'b0));
        pushed++;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (popped != pushed || exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d popped required=%0d", popped, pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: compares the DUT outputs after each edge against the queued expectation.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle_outputs x=%0d y=%0d actual=%h required=%h", xpos, ypos, act, e);
        end
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next generation of the fixed 800x600@72 timing block. It produces sync, raster coordinates and text-cell addressing for any mode set by parameters, with programmable sync polarity and character-cell geometry. It also adds a pixel clock enable, line and frame strobes, and a frame counter with a blink phase. It sits between the system clock and the character fetch / pixel drawing pipeline.

## Interface
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync pulse (pixels)
- H_BACK, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync pulse (lines)
- V_BACK, 23, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active low)
- VSYNC_POL, 0, vsync active level (0 = active low)
- CHAR_W, 8, character cell width (pixels, power of 2)
- CHAR_H, 10, character cell height (lines, any value ≥ 1)
- LOAD_LEAD, 7, cycles by which the char-load window precedes the drawing window
- DESIGN_DELAY, 2, offset of the design-load strobe after the char-load strobe
- COORD_W, 11, width of xpos/ypos
- COL_W, 7, width of xtext; ROW_W, 6, width of ytext
- BLINK_BIT, 5, frame_count bit used as blink phase
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  pixel enable; counters advance only when ce=1
- hsync, vsync  out  1  sync outputs at the configured polarity
- xpos, ypos  out  COORD_W  raster position (registered)
- xchar  out  clog2(CHAR_W)  pixel column within cell
- ychar  out  clog2(CHAR_H)  line within cell
- xtext  out  COL_W  text column; ytext  out  ROW_W  text row
- drawing, loading  out  1  visible window / char-load window
- clk_load_char, clk_load_design, clk_draw_char  out  1  per-cell strobes
- line_start, frame_start  out  1  strobes at xpos=0 / (xpos,ypos)=(0,0)
- frame_count  out  8  completed-frame counter; blink  out  1  frame_count[BLINK_BIT]

## Operation
- H_TOTAL = H_BACK+H_VISIBLE+H_FRONT+H_SYNC. V_TOTAL is defined the same way from the vertical parameters. Each line is ordered back porch, visible, front porch, sync, starting at xpos=0.
- On each clk edge with ce=1, xpos increments. When xpos=H_TOTAL-1, xpos wraps to 0 and ypos increments, wrapping at V_TOTAL-1.
- frame_count increments (mod 256) on the same edge as the ypos wrap. With ce=0, all registers hold.
- hsync is active for xpos in [H_BACK+H_VISIBLE+H_FRONT, H_TOTAL); vsync is defined the same way on ypos.
- Drawing windows: hdraw = xpos in [H_BACK, H_BACK+H_VISIBLE); vdraw = ypos in [V_BACK, V_BACK+V_VISIBLE); drawing = hdraw & vdraw.
- loading = vdraw & xpos in [H_BACK-LOAD_LEAD, H_BACK+H_VISIBLE-LOAD_LEAD).
- Text addressing:
  - xtext = loading ? (xpos-H_BACK+LOAD_LEAD)/CHAR_W : 0.
  - xchar = drawing ? (xpos-H_BACK) mod CHAR_W : 0.
  - ytext = vdraw ? (ypos-V_BACK)/CHAR_H : 0.
  - ychar = drawing ? (ypos-V_BACK) mod CHAR_H : 0.
- ytext/ychar come from incremental row/line-in-cell counters, not dividers.
  - Both clear on the edge that enters ypos=V_BACK.
  - The line-in-cell counter steps at each line wrap and returns to 0 after CHAR_H-1, incrementing the row counter.
- Strobes:
  - clk_load_char = 1 for xpos in the load window with (xpos-H_BACK+LOAD_LEAD) mod CHAR_W = 0. It is not gated by vdraw.
  - clk_load_design is the same test shifted by DESIGN_DELAY.
  - clk_draw_char = drawing & xchar=0.
  - line_start and frame_start are not gated by ce.
- All outputs are combinational from registered state, so there is zero latency relative to xpos/ypos.

## Timing
- Reset is asynchronous. While reset=1:
  - xpos, ypos, frame_count and the cell counters are 0.
  - hsync = ~HSYNC_POL and vsync = ~VSYNC_POL (inactive).
  - drawing, loading, every strobe, xtext/ytext/xchar/ychar and blink are forced to 0.
- The first ce=1 edge after reset releases moves xpos to 1.
- Reset mid-frame restarts at (0,0) with frame_count=0. No partial state survives.
- Simultaneous wraps of xpos and ypos on one edge: ypos→0, frame_count increments, and the cell counters are already idle (vdraw=0).
- A frame is H_TOTAL·V_TOTAL ce-cycles long; with defaults this is 1040·666 = 692640.

## Test plan
- Reset, then ce=1 constantly:
  - xpos runs 0..1039 and wraps; hsync=0 exactly for xpos 920..1039.
  - vsync=0 exactly for ypos 660..665; line_start=1 only at xpos=0.
- At ypos=33:
  - drawing first rises at xpos=64; xchar=0 and clk_draw_char=1 there, xchar=7 at xpos=71.
  - ychar=0 and ytext=1 at ypos=33; ychar=9 and ytext=0 at ypos=32.
- Loading strobes on line ypos=23:
  - clk_load_char at xpos 57, 65, …, 849, with xtext=0 at 57 and xtext=99 at 849–856.
  - clk_load_design at xpos 59, 67, …, 851.
- Run 692640 cycles:
  - frame_start pulses at the start and end of the run; frame_count steps 0→1.
  - After 32 frames, blink=1.
- ce toggled 1/0 alternately: xpos advances once per two clocks, and outputs are stable during ce=0 cycles.
- Reset asserted asynchronously at (500,300):
  - Outputs go to their reset values before the next clk edge.
  - After release, the sequence restarts from (0,0) with frame_count=0.
- Alternate parameterisation (640x480@60: 16/96/48, 10/2/33, CHAR_H=16, HSYNC_POL=VSYNC_POL=0):
  - H_TOTAL=800, V_TOTAL=525; hsync active for xpos 704..799.
  - ytext=29 on the last visible line.
